nbit_serializer: RTL and testbench
==================================

NBIT_SERIALIZER -- requirements
Module: nbit_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width in bits (legal range 2..64).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port en  input  1  global enable; low = full stall, all state held.
REQ-005 SHALL have port in_valid  input  1  parallel word offered.
REQ-006 SHALL have port in_data  input  WIDTH  parallel word to serialize.
REQ-007 SHALL have port in_ready  output  1  block can accept a word this cycle.
REQ-008 SHALL have port ser_out  output  1  serial data bit.
REQ-009 SHALL have port ser_valid  output  1  ser_out carries a valid bit this cycle.
REQ-010 SHALL have port ser_first  output  1  current bit is bit 0 of a word.
REQ-011 SHALL have port ser_last  output  1  current bit is the final serial bit of a word.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT, PARITY (PARITY exists only with the Configuration macro).
REQ-013 SHALL accept a word on a rising edge where in_valid & in_ready & en are all 1.
REQ-014 SHALL drive in_ready = en & ((state==IDLE) | (state==SHIFT & cnt==WIDTH-1 & macro absent) | (state==PARITY)).
REQ-015 On accept, SHALL load shift register with in_data, clear bit counter cnt ($clog2(WIDTH) bits), enter SHIFT.
REQ-016 SHALL serialize LSB first; bit 0 appears on ser_out in the cycle immediately after the accept edge (latency 1).
REQ-017 SHALL drive ser_out = shift register bit 0 in SHIFT, computed parity bit in PARITY, 0 in IDLE.
REQ-018 SHALL drive ser_valid = en & (state!=IDLE); ser_first = ser_valid & state==SHIFT & cnt==0.
REQ-019 In SHIFT with en=1, SHALL shift right by one and increment cnt each cycle.
REQ-020 At cnt==WIDTH-1 with en=1, SHALL go to PARITY (macro defined), else to SHIFT with new word if accepted, else IDLE.
REQ-021 SHALL drive ser_last = ser_valid & ((state==SHIFT & cnt==WIDTH-1 & macro absent) | state==PARITY).
REQ-022 Back-to-back words SHALL stream with zero idle cycles between last bit of word N and bit 0 of word N+1.
REQ-023 With en=0, SHALL hold state, cnt, shift register; in_ready, ser_valid, ser_first, ser_last SHALL be 0.
REQ-024 in_data SHALL be sampled only on accept edge; changes at other times SHALL not affect output.

Reset
REQ-025 reset=1 at a rising edge SHALL force IDLE, cnt=0, shift register=0, parity=0, regardless of en or mid-word state.
REQ-026 After reset, ser_out, ser_valid, ser_first, ser_last SHALL be 0; in_ready SHALL equal en.
REQ-027 A word interrupted by reset SHALL be discarded; no remaining bits emitted.

Configuration
REQ-028 Macro NBIT_SERIALIZER_PARITY_EN defined SHALL append one even-parity bit (XOR of accepted word) after bit WIDTH-1, in PARITY state, frame length WIDTH+1.
REQ-029 Macro absent SHALL omit PARITY state and parity register; frame length WIDTH.

Structure
REQ-030 SHALL place FSM state encoding (IDLE=0, SHIFT=1, PARITY=2, 2 bits) in shared package nbit_serializer_pkg.
REQ-031 SHALL implement shift register as sub-module nbit_shift_reg (WIDTH, parallel load, shift-right, enable, sync reset).

Verification
REQ-032 WIDTH=8, one word 0xA5 accepted cycle 0 -> ser_out 1,0,1,0,0,1,0,1 cycles 1-8; ser_first cycle 1; ser_last cycle 8; in_ready 0 cycles 1-7.
REQ-033 WIDTH=8, in_valid held with 0x01 then 0xFF -> 16 contiguous ser_valid cycles, no gap, ser_first at cycles 1 and 9.
REQ-034 WIDTH=8, en=0 for 3 cycles after bit 3 of 0x3C -> outputs flagged invalid 3 cycles, bits 4-7 (1,1,0,0) resume unchanged.
REQ-035 WIDTH=8, reset asserted during bit 5 of 0xF0 -> next cycle ser_valid=0, state IDLE, no further bits of 0xF0.
REQ-036 NBIT_SERIALIZER_PARITY_EN, WIDTH=8, 0x07 -> 8 data bits then parity bit 1 at cycle 9 with ser_last; next word bit 0 at cycle 10.
REQ-037 in_data toggled to 0x00 every cycle after accepting 0xC3 -> serial stream still 1,1,0,0,0,0,1,1.

Source files
------------

// File: rtl/nbit_serializer_pkg.sv
// Shared definitions for the N-bit serializer: FSM state encoding.
package nbit_serializer_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2
   } state_t;

endpackage

// File: rtl/nbit_shift_reg.sv
// Parallel-load, shift-right register with enable and synchronous reset.
// Only bit 0 leaves the block; upper bits feed it one step at a time.
module nbit_shift_reg #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] load_data,
   output logic             lsb
);

   logic [WIDTH-1:0] data_reg;
   logic [WIDTH-1:0] data_next;

   // Load takes priority over shift so a back-to-back word replaces the old one
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic from_left;
      if (gi == WIDTH - 1) begin : g_top
         assign from_left = 1'b0;
      end else begin : g_mid
         assign from_left = data_reg[gi+1];
      end
      assign data_next[gi] = load ? load_data[gi] : (shift ? from_left : data_reg[gi]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         data_reg <= '0;
      end else begin
         data_reg <= data_next;
      end
   end

   assign lsb = data_reg[0];

endmodule

// File: rtl/nbit_serializer.sv
// LSB-first word serializer with first/last framing and global stall.
// Define NBIT_SERIALIZER_PARITY_EN to append an even-parity bit to each frame.
module nbit_serializer
   import nbit_serializer_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             ser_first,
   output logic             ser_last
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             accept;
   logic             at_last;
   logic             shift_en;
   logic             data_bit;
   logic             parity_bit;

`ifdef NBIT_SERIALIZER_PARITY_EN
   localparam bit HAS_PARITY = 1'b1;
   logic parity_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         parity_reg <= 1'b0;
      end else if (accept) begin
         parity_reg <= ^in_data;
      end
   end

   assign parity_bit = parity_reg;
`else
   localparam bit HAS_PARITY = 1'b0;
   assign parity_bit = 1'b0;
`endif

   assign at_last  = (state_reg == SHIFT) && (cnt_reg == CNT_LAST);
   assign in_ready = en & ((state_reg == IDLE) | (at_last & !HAS_PARITY) | (state_reg == PARITY));
   assign accept   = in_valid & in_ready;
   assign shift_en = en & (state_reg == SHIFT) & !accept;

   nbit_shift_reg #(.WIDTH(WIDTH)) u_shift (
      .clk       (clk),
      .reset     (reset),
      .load      (accept),
      .shift     (shift_en),
      .load_data (in_data),
      .lsb       (data_bit)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      if (en) begin
         case (state_reg)
            IDLE: begin
               cnt_next = '0;
               if (accept) state_next = SHIFT;
            end
            SHIFT: begin
               if (cnt_reg == CNT_LAST) begin
                  cnt_next = '0;
                  if (HAS_PARITY)  state_next = PARITY;
                  else if (accept) state_next = SHIFT;
                  else             state_next = IDLE;
               end else begin
                  cnt_next = cnt_reg + 1'b1;
               end
            end
            PARITY: begin
               cnt_next   = '0;
               state_next = accept ? SHIFT : IDLE;
            end
            default: begin
               cnt_next   = '0;
               state_next = IDLE;
            end
         endcase
      end
   end

   always_comb begin
      ser_out = 1'b0;
      case (state_reg)
         SHIFT:   ser_out = data_bit;
         PARITY:  ser_out = parity_bit;
         default: ser_out = 1'b0;
      endcase
   end

   assign ser_valid = en & (state_reg != IDLE);
   assign ser_first = ser_valid & (state_reg == SHIFT) & (cnt_reg == '0);
   assign ser_last  = ser_valid & ((at_last & !HAS_PARITY) | (state_reg == PARITY));

endmodule

// File: tb/tb_nbit_serializer.sv
// Scoreboard bench for nbit_serializer (WIDTH=8): accepted words become queued
// expected bits; a negedge monitor compares every presented serial bit.
module tb_nbit_serializer;

   localparam int W = 8;
`ifdef NBIT_SERIALIZER_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   typedef struct {
      logic b;
      logic f;
      logic l;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         en = 1'b1;
   logic         in_valid = 1'b0;
   logic [W-1:0] in_data = '0;
   logic         in_ready, ser_out, ser_valid, ser_first, ser_last;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   accept_count = 0;
   bit   chk_on = 1'b0;

   always #5 clk = ~clk;

   nbit_serializer #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .ser_out   (ser_out),
      .ser_valid (ser_valid),
      .ser_first (ser_first),
      .ser_last  (ser_last)
   );

   function automatic void check(string name, logic act, logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endfunction

   // Reference model at the edge: reset discards the frame, an accepted word
   // becomes a frame of expected bits. The model is ready only once the frame
   // in flight has been fully consumed.
   always @(posedge clk) begin
      if (reset) begin
         sb.delete();
      end else if (en && in_valid && sb.size() == 0) begin
         for (int i = 0; i < W; i++) begin
            exp_t e;
            e.b = in_data[i];
            e.f = (i == 0);
            e.l = (i == W - 1) && !PAR;
            sb.push_back(e);
         end
         if (PAR) begin
            exp_t p;
            p.b = ^in_data;
            p.f = 1'b0;
            p.l = 1'b1;
            sb.push_back(p);
         end
         accept_count++;
         $display("accept word %02h (frame %0d)", in_data, accept_count);
      end
   end

   // Monitor: compares the presented bit against the queue head, then consumes it
   always @(negedge clk) begin
      if (chk_on) begin
         logic exp_valid;
         exp_valid = en && (sb.size() > 0);
         check("ser_valid", ser_valid, exp_valid);
         check("in_ready", in_ready, en && (sb.size() <= 1));
         if (exp_valid && ser_valid) begin
            exp_t e;
            e = sb.pop_front();
            check("ser_out", ser_out, e.b);
            check("ser_first", ser_first, e.f);
            check("ser_last", ser_last, e.l);
            $display("bit out=%b first=%b last=%b", ser_out, ser_first, ser_last);
         end else begin
            if (exp_valid) void'(sb.pop_front());
            check("ser_first_idle", ser_first, 1'b0);
            check("ser_last_idle", ser_last, 1'b0);
            if (sb.size() == 0) check("ser_out_idle", ser_out, 1'b0);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [W-1:0] w);
      int start;
      int t;
      start = accept_count;
      in_valid = 1'b1;
      in_data = w;
      t = 0;
      while (accept_count == start && t < 200) begin
         step();
         t++;
      end
      checks++;
      if (accept_count == start) begin
         errors++;
         $display("FAIL accept_timeout: got no accept expected accept of %02h", w);
      end
      in_valid = 1'b0;
      in_data = W'($urandom);
   endtask

   task automatic drain();
      int t;
      en = 1'b1;
      in_valid = 1'b0;
      t = 0;
      while (sb.size() != 0 && t < 100) begin
         step();
         t++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: got %0d pending bits expected 0", sb.size());
      end
   endtask

   initial begin
      reset = 1'b1;
      step();
      chk_on = 1'b1;
      step();
      reset = 1'b0;
      step();

      // Single word, LSB first
      send(8'hA5);
      drain();
      step();

      // Back-to-back stream with in_valid held
      in_valid = 1'b1;
      in_data = 8'h01;
      while (accept_count < 3) step();
      in_data = 8'hFF;
      send(8'hFF);
      drain();

      // Stall for three cycles mid-word
      send(8'h3C);
      repeat (3) step();
      en = 1'b0;
      repeat (3) step();
      en = 1'b1;
      drain();

      // Reset in the middle of a word discards it
      send(8'hF0);
      repeat (5) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      step();
      drain();

      // in_data changes after accept must not leak into the stream
      send(8'hC3);
      for (int i = 0; i < W; i++) begin
         in_data = (i % 2 == 0) ? 8'h00 : 8'hFF;
         step();
      end
      drain();

      // Randomized traffic with stalls and occasional resets
      for (int i = 0; i < 400; i++) begin
         en       = ($urandom_range(0, 7) != 0);
         in_valid = ($urandom_range(0, 2) != 0);
         in_data  = W'($urandom);
         reset    = ($urandom_range(0, 79) == 0);
         step();
      end
      reset = 1'b0;
      drain();
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
